// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared constants for the pipeline hazard/sequencing controller.
//   state_t     : 2-bit controller state type
//   RUN         : normal pipeline operation
//   MEM_WAIT    : pipe frozen while data memory has not acknowledged
//   HALT        : memory timeout occurred, core stopped until reset
//   REG_ADDR_W  : width of a register-file address
//   REG_ZERO    : hard-wired zero register, never a hazard source
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [1:0] state_t;

    localparam state_t RUN      = 2'b00;
    localparam state_t MEM_WAIT = 2'b01;
    localparam state_t HALT     = 2'b10;

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Flags a load-use hazard: the instruction in ID/EX is a load whose
// destination register is a source of the instruction in IF/ID.
//   EXMemRead : ID/EX stage holds a load
//   EXrt      : load destination register in ID/EX
//   IDrs/IDrt : source register fields of the instruction in IF/ID
//   hazard    : 1 when a one-cycle bubble is needed
// ---------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  EXMemRead,
    input  logic [REG_ADDR_W-1:0] EXrt,
    input  logic [REG_ADDR_W-1:0] IDrs,
    input  logic [REG_ADDR_W-1:0] IDrt,
    output logic                  hazard
);

    // A load into $0 writes nothing, so it can never feed a younger instruction.
    always_comb begin
        hazard = EXMemRead && (EXrt != REG_ZERO) &&
                 ((EXrt == IDrs) || (EXrt == IDrt));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central sequencer for the IF/ID, ID/EX, EX/MEM, MEM/WB registers and PC.
// Inserts load-use bubbles, redirects/flushes on taken branches resolved in
// MEM, and freezes the pipe while a data-memory access awaits acknowledge,
// halting the core if the wait exceeds MEM_TIMEOUT cycles.
//
// Parameters : MEM_TIMEOUT (max MEM_WAIT cycles), CNT_W (wait counter width)
// Inputs     : Clk, Reset (async, active high), IDrs, IDrt, EXMemRead, EXrt,
//              MEMBranch, MEMzero, MEMMemRead, MEMMemWrite, MemAck
// Outputs    : PCWrite, PCSrc, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
//              EXMEMEnable, EXMEMFlush, MEMWBFlush, MemReq, MemTimeout
// Optional   : macro PERF_CNT_EN adds StallCycles[31:0] and FlushCount[15:0]
//              saturating performance counters.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
)
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [REG_ADDR_W-1:0] IDrs,
    input  logic [REG_ADDR_W-1:0] IDrt,
    input  logic                  EXMemRead,
    input  logic [REG_ADDR_W-1:0] EXrt,
    input  logic                  MEMBranch,
    input  logic                  MEMzero,
    input  logic                  MEMMemRead,
    input  logic                  MEMMemWrite,
    input  logic                  MemAck,
    output logic                  PCWrite,
    output logic                  PCSrc,
    output logic                  IFIDWrite,
    output logic                  IFIDFlush,
    output logic                  IDEXWrite,
    output logic                  IDEXFlush,
    output logic                  EXMEMEnable,
    output logic                  EXMEMFlush,
    output logic                  MEMWBFlush,
    output logic                  MemReq,
    output logic                  MemTimeout
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]           StallCycles,
    output logic [15:0]           FlushCount
`endif
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             load_use;
    logic             branch_taken;
    logic             mem_access;

    load_use_detect u_load_use_detect (
        .EXMemRead (EXMemRead),
        .EXrt      (EXrt),
        .IDrs      (IDrs),
        .IDrt      (IDrt),
        .hazard    (load_use)
    );

    assign branch_taken = MEMBranch && MEMzero;
    assign mem_access   = MEMMemRead || MEMMemWrite;

    // Output decode and next-state logic. Outputs start from the RUN
    // defaults (everything advances) and each case only overrides what it
    // must. A freeze stops every stage up to EX/MEM and pushes a bubble into
    // MEM/WB so the stalled memory op is not written back twice.
    always_comb begin
        PCWrite       = 1'b1;
        IFIDWrite     = 1'b1;
        IDEXWrite     = 1'b1;
        EXMEMEnable   = 1'b1;
        PCSrc         = 1'b0;
        IFIDFlush     = 1'b0;
        IDEXFlush     = 1'b0;
        EXMEMFlush    = 1'b0;
        MEMWBFlush    = 1'b0;
        MemReq        = 1'b0;
        MemTimeout    = 1'b0;
        state_next    = state;
        wait_cnt_next = wait_cnt;

        if (Reset) begin
            PCWrite       = 1'b0;
            IFIDWrite     = 1'b0;
            IDEXWrite     = 1'b0;
            EXMEMEnable   = 1'b0;
            IFIDFlush     = 1'b1;
            IDEXFlush     = 1'b1;
            EXMEMFlush    = 1'b1;
            MEMWBFlush    = 1'b1;
            state_next    = RUN;
            wait_cnt_next = '0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        PCSrc      = 1'b1;
                        IFIDFlush  = 1'b1;
                        IDEXFlush  = 1'b1;
                        EXMEMFlush = 1'b1;
                    end else if (mem_access) begin
                        MemReq = 1'b1;
                        // Without an immediate ack the freeze starts now, so
                        // this cycle already counts as the first wait cycle.
                        if (!MemAck) begin
                            PCWrite       = 1'b0;
                            IFIDWrite     = 1'b0;
                            IDEXWrite     = 1'b0;
                            EXMEMEnable   = 1'b0;
                            MEMWBFlush    = 1'b1;
                            state_next    = MEM_WAIT;
                            wait_cnt_next = CNT_W'(1);
                        end
                    end else if (load_use) begin
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        IDEXFlush = 1'b1;
                    end
                end

                MEM_WAIT: begin
                    MemReq = 1'b1;
                    // An ack always wins over the timeout compare, even on
                    // the final allowed cycle.
                    if (MemAck) begin
                        state_next    = RUN;
                        wait_cnt_next = '0;
                    end else begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEXWrite   = 1'b0;
                        EXMEMEnable = 1'b0;
                        MEMWBFlush  = 1'b1;
                        if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                            state_next = HALT;
                        end else begin
                            wait_cnt_next = wait_cnt + CNT_W'(1);
                        end
                    end
                end

                HALT: begin
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IDEXWrite   = 1'b0;
                    EXMEMEnable = 1'b0;
                    MemTimeout  = 1'b1;
                end

                default: begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            endcase
        end
    end

    // State and wait counter. HALT is only left through Reset, so the
    // sticky timeout flag is simply "state is HALT".
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

`ifdef PERF_CNT_EN
    // Saturating performance counters: stall cycles are any live (non-HALT)
    // cycle where the PC is held; flushes count taken branches in RUN.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (((state == RUN) || (state == MEM_WAIT)) && !PCWrite &&
                (StallCycles != '1)) begin
                StallCycles <= StallCycles + 32'd1;
            end
            if ((state == RUN) && branch_taken && (FlushCount != '1)) begin
                FlushCount <= FlushCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl. A behavioural model classifies
// each cycle (reset, halted, frozen, memory advance, branch, bubble, normal)
// and the compare process checks every output at each falling edge. Directed
// sequences with literal expectations pin the model, then a randomized
// phase exercises mixed traffic with periodic resets.
// Honours PERF_CNT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;

    // Output vector order:
    // {PCWrite, PCSrc, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
    //  EXMEMEnable, EXMEMFlush, MEMWBFlush, MemReq, MemTimeout}
    localparam logic [10:0] P_RESET  = 11'b00010101100;
    localparam logic [10:0] P_RUN    = 11'b10101010000;
    localparam logic [10:0] P_BUBBLE = 11'b00001110000;
    localparam logic [10:0] P_BRANCH = 11'b11111111000;
    localparam logic [10:0] P_FROZEN = 11'b00000000110;
    localparam logic [10:0] P_MEMADV = 11'b10101010010;
    localparam logic [10:0] P_HALT   = 11'b00000000001;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       mem_branch;
    logic       mem_zero;
    logic       mem_read;
    logic       mem_write;
    logic       mem_ack;
    logic       pc_write;
    logic       pc_src;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_write;
    logic       idex_flush;
    logic       exmem_enable;
    logic       exmem_flush;
    logic       memwb_flush;
    logic       mem_req;
    logic       mem_timeout;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    logic [10:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit    m_waiting = 1'b0;
    bit    m_halted  = 1'b0;
    int    m_waited  = 0;
    longint m_stall  = 0;
    longint m_flush  = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (TIMEOUT),
        .CNT_W       (4)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .IDrs        (id_rs),
        .IDrt        (id_rt),
        .EXMemRead   (ex_mem_read),
        .EXrt        (ex_rt),
        .MEMBranch   (mem_branch),
        .MEMzero     (mem_zero),
        .MEMMemRead  (mem_read),
        .MEMMemWrite (mem_write),
        .MemAck      (mem_ack),
        .PCWrite     (pc_write),
        .PCSrc       (pc_src),
        .IFIDWrite   (ifid_write),
        .IFIDFlush   (ifid_flush),
        .IDEXWrite   (idex_write),
        .IDEXFlush   (idex_flush),
        .EXMEMEnable (exmem_enable),
        .EXMEMFlush  (exmem_flush),
        .MEMWBFlush  (memwb_flush),
        .MemReq      (mem_req),
        .MemTimeout  (mem_timeout)
`ifdef PERF_CNT_EN
        ,
        .StallCycles (stall_cycles),
        .FlushCount  (flush_count)
`endif
    );

    assign dut_vec = {pc_write, pc_src, ifid_write, ifid_flush, idex_write,
                      idex_flush, exmem_enable, exmem_flush, memwb_flush,
                      mem_req, mem_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [10:0] act,
                               input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [4:0] rt_ex,
                                 input logic [4:0] rs_id, input logic [4:0] rt_id,
                                 input logic br, input logic zero,
                                 input logic rd, input logic wr, input logic ack);
        ex_mem_read = ld;
        ex_rt       = rt_ex;
        id_rs       = rs_id;
        id_rt       = rt_id;
        mem_branch  = br;
        mem_zero    = zero;
        mem_read    = rd;
        mem_write   = wr;
        mem_ack     = ack;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expectNow(input string name, input logic [10:0] exp);
        #1;
        checkOutput(name, dut_vec, exp);
    endtask

    // Reference model and per-cycle compare. Each cycle is classified by
    // what the pipeline must do, then the model advances its notion of
    // "waiting on memory for N cycles" / "halted".
    always @(negedge clk) begin : model_compare
        logic [10:0] exp_v;
        bit br;
        bit acc;
        bit lu;
        br  = mem_branch && mem_zero;
        acc = mem_read || mem_write;
        lu  = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        if (rst) begin
            m_waiting = 1'b0;
            m_halted  = 1'b0;
            m_waited  = 0;
            m_stall   = 0;
            m_flush   = 0;
            exp_v     = P_RESET;
        end else if (m_halted) begin
            exp_v = P_HALT;
        end else if (m_waiting) begin
            exp_v = mem_ack ? P_MEMADV : P_FROZEN;
        end else if (br) begin
            exp_v = P_BRANCH;
        end else if (acc) begin
            exp_v = mem_ack ? P_MEMADV : P_FROZEN;
        end else if (lu) begin
            exp_v = P_BUBBLE;
        end else begin
            exp_v = P_RUN;
        end

        checkOutput("cycle_outputs", dut_vec, exp_v);
`ifdef PERF_CNT_EN
        checkCount("cycle_stall_cycles", longint'(stall_cycles), m_stall);
        checkCount("cycle_flush_count", longint'(flush_count), m_flush);
`endif

        if (!rst && !m_halted) begin
            if (!exp_v[10] && m_stall < 64'h0000_0000_FFFF_FFFF) m_stall++;
            if (!m_waiting && br && m_flush < 64'h0000_0000_0000_FFFF) m_flush++;
            if (m_waiting) begin
                if (mem_ack) begin
                    m_waiting = 1'b0;
                    m_waited  = 0;
                end else if (m_waited == TIMEOUT) begin
                    m_halted = 1'b1;
                end else begin
                    m_waited++;
                end
            end else if (!br && acc && !mem_ack) begin
                m_waiting = 1'b1;
                m_waited  = 1;
            end
        end
    end

    // Directed sequences followed by randomized traffic.
    initial begin
        int halt_run;
        halt_run = 0;
        rst = 1'b1;
        idle();
        #2;
        checkOutput("reset_outputs", dut_vec, P_RESET);
        step();
        step();
        rst = 1'b0;
        expectNow("run_default", P_RUN);
        step();

        // Load-use bubbles and the $0 exception
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expectNow("load_use_rs", P_BUBBLE);
        step();
        idle();
        expectNow("after_load_use", P_RUN);
        step();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expectNow("load_use_r0", P_RUN);
        step();
        applyStimulus(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expectNow("load_use_rt", P_BUBBLE);
        step();

        // Taken branch overrides load-use and memory access
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expectNow("branch_over_lu", P_BRANCH);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expectNow("branch_over_mem", P_BRANCH);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expectNow("branch_not_taken", P_RUN);
        step();

        // Three-cycle memory wait then ack
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            expectNow("mem_wait_frozen", P_FROZEN);
            step();
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        expectNow("mem_ack_advance", P_MEMADV);
        step();
        idle();
        expectNow("mem_back_run", P_RUN);
        step();

        // Zero-wait access
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        expectNow("mem_zero_wait", P_MEMADV);
        step();

        // Load-use during a freeze is deferred until after the ack cycle
        applyStimulus(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expectNow("deferred_lu_frozen", P_FROZEN);
        step();
        applyStimulus(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        expectNow("deferred_lu_ack", P_MEMADV);
        step();
        applyStimulus(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expectNow("deferred_lu_bubble", P_BUBBLE);
        step();

        // Timeout: first freeze cycle plus TIMEOUT wait cycles, then HALT
        for (int i = 0; i <= TIMEOUT; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            expectNow("timeout_frozen", P_FROZEN);
            step();
        end
        expectNow("halt_entered", P_HALT);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        expectNow("halt_sticky", P_HALT);
        step();
        rst = 1'b1;
        expectNow("reset_from_halt", P_RESET);
        step();
        rst = 1'b0;
        idle();
        expectNow("run_after_halt", P_RUN);
        step();

        // Ack on the exact timeout cycle wins
        for (int i = 0; i < TIMEOUT; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            expectNow("edge_frozen", P_FROZEN);
            step();
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expectNow("edge_ack_wins", P_MEMADV);
        step();
        idle();
        expectNow("edge_no_timeout", P_RUN);
        step();

        // Async reset in the middle of a wait
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expectNow("midwait_frozen", P_FROZEN);
        step();
        expectNow("midwait_frozen2", P_FROZEN);
        rst = 1'b1;
        expectNow("reset_mid_wait", P_RESET);
        step();
        rst = 1'b0;
        idle();
        expectNow("run_after_midwait_reset", P_RUN);
        step();

`ifdef PERF_CNT_EN
        checkCount("perf_stall_cleared", longint'(stall_cycles), 0);
        checkCount("perf_flush_cleared", longint'(flush_count), 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            idle();
            step();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step();
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        idle();
        step();
        #1;
        checkCount("perf_stall_five", longint'(stall_cycles), 5);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        idle();
        step();
        #1;
        checkCount("perf_flush_two", longint'(flush_count), 2);
        step();
`endif

        // Randomized traffic; HALT and occasional random resets are recovered
        // with a one-cycle reset pulse.
        for (int n = 0; n < 1500; n++) begin
            if (rst) begin
                rst = 1'b0;
            end else if (m_halted) begin
                halt_run++;
                if (halt_run > 3) begin
                    rst      = 1'b1;
                    halt_run = 0;
                end
            end else if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
            end
            applyStimulus(1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 9) < 5));
            step();
        end

        rst = 1'b0;
        idle();
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards and inserts bubbles.
- Resolves taken branches in MEM, redirects the PC and flushes younger stages.
- Freezes the pipe while a data-memory access waits for acknowledge, with a timeout that halts the core.

Parameters:
MEM_TIMEOUT, 15, max cycles spent in MEM_WAIT before timeout (1..2^CNT_W-1)
CNT_W, 4, width of wait-cycle counter

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
IDrs  in  5  rs field of instruction in IF/ID
IDrt  in  5  rt field of instruction in IF/ID
EXMemRead  in  1  ID/EX stage holds a load
EXrt  in  5  load destination register in ID/EX
MEMBranch  in  1  EX/MEM branch flag
MEMzero  in  1  EX/MEM ALU zero flag
MEMMemRead  in  1  EX/MEM load
MEMMemWrite  in  1  EX/MEM store
MemAck  in  1  data memory completes current access
PCWrite  out  1  PC load enable
PCSrc  out  1  1 = select branch target (EX/MEM add result)
IFIDWrite  out  1  IF/ID load enable
IFIDFlush  out  1  IF/ID clear to NOP
IDEXWrite  out  1  ID/EX load enable
IDEXFlush  out  1  ID/EX clear control bits to 0
EXMEMEnable  out  1  EX/MEM load enable
EXMEMFlush  out  1  EX/MEM clear control bits to 0
MEMWBFlush  out  1  MEM/WB clear control bits (bubble)
MemReq  out  1  data-memory request strobe
MemTimeout  out  1  sticky: memory timeout occurred

Behaviour:
- States: RUN, MEM_WAIT, HALT. State register and wait counter reset asynchronously on Reset.
- Outputs are combinational from state and inputs.
- While Reset is high:
  - All Write/Enable outputs are 0.
  - All Flush outputs are 1.
  - PCSrc, MemReq and MemTimeout are 0.
- Default in RUN: all Write/Enable outputs = 1, all Flush outputs = 0, PCSrc = 0.
- Priority in RUN (highest first):
  1. Branch taken (MEMBranch & MEMzero):
     - PCSrc = 1.
     - IFIDFlush, IDEXFlush and EXMEMFlush = 1 for one cycle.
     - Stay in RUN.
     - Overrides load-use and memory access in the same cycle.
  2. Memory access (MEMMemRead | MEMMemWrite):
     - MemReq = 1.
     - If MemAck is already 1: zero-wait, normal advance, stay in RUN.
     - Else: PCWrite, IFIDWrite, IDEXWrite and EXMEMEnable = 0; MEMWBFlush = 1; go to MEM_WAIT; counter = 1.
  3. Load-use hazard (EXMemRead & EXrt != 0 & (EXrt == IDrs | EXrt == IDrt)):
     - PCWrite = 0, IFIDWrite = 0, IDEXFlush = 1 for exactly one cycle.
     - Other stages advance.
     - A load-use coinciding with a memory wait is deferred: it re-evaluates after the freeze ends.
- MEM_WAIT:
  - MemReq = 1.
  - Pipe frozen: PCWrite, IFIDWrite, IDEXWrite and EXMEMEnable = 0; MEMWBFlush = 1.
  - On MemAck: the same cycle outputs RUN defaults, so the pipe advances and the memory stage result is captured; next state is RUN; counter cleared.
  - If there is no ack and counter == MEM_TIMEOUT: next state is HALT and MemTimeout is set; otherwise counter increments.
  - An ack arriving in the same cycle the counter reaches MEM_TIMEOUT wins, and no timeout is raised.
- HALT:
  - All Write/Enable outputs = 0, all Flush outputs = 0, MemReq = 0, MemTimeout = 1.
  - Exit only by Reset.
- Reset mid-MEM_WAIT: immediate return to RUN state encoding; counter and MemTimeout cleared.
- Register $0 never causes a load-use stall.

Optional Feature:
PERF_CNT_EN
- Defined: adds output ports StallCycles [31:0] and FlushCount [15:0].
  - Both clear on Reset and saturate at all-ones.
  - StallCycles increments on each cycle with PCWrite = 0 in RUN or MEM_WAIT.
  - FlushCount increments on each taken-branch cycle.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg:
  - state encoding constants RUN = 2'b00, MEM_WAIT = 2'b01, HALT = 2'b10;
  - REG_ZERO = 5'd0;
  - REG_ADDR_W = 5.
- Sub-module load_use_detect: combinational compare of EXMemRead/EXrt against IDrs/IDrt; outputs a hazard bit.

Test Plan:
- Load-use: EXMemRead = 1, EXrt = 5, IDrs = 5 -> one cycle with PCWrite = 0, IFIDWrite = 0, IDEXFlush = 1; the next cycle returns to defaults. Repeat with EXrt = 0 -> no stall.
- Branch: MEMBranch = 1, MEMzero = 1 with a concurrent load-use -> PCSrc = 1, IFID/IDEX/EXMEM flush = 1, PCWrite = 1, no stall.
- Memory wait: MEMMemRead = 1, MemAck low 3 cycles then high -> 3 frozen cycles with MemReq = 1 and MEMWBFlush = 1; the ack cycle shows all enables = 1; back in RUN.
- Timeout: MEM_TIMEOUT = 4, MEMMemWrite = 1, MemAck never -> after the 4th wait cycle, HALT with MemTimeout = 1 and all enables 0 indefinitely. Ack on the exact timeout cycle -> RUN, no timeout.
- Async reset asserted mid-MEM_WAIT -> outputs immediately take reset values (flushes = 1, enables = 0); after release, RUN defaults with MemTimeout = 0.
- PERF_CNT_EN: 2 load-use stalls plus a 3-cycle memory wait -> StallCycles = 5; 2 taken branches -> FlushCount = 2.
